// File: rtl/mcycle_ctrl_pkg.sv
// ============================================================================
// Module      : mcycle_ctrl_pkg
// Description : State encodings, opcodes and opcode classification shared by
//               the multicycle sequencer and its performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcycle_ctrl_pkg;

   typedef enum logic [2:0] {
      STATE_IF   = 3'd0,
      STATE_ID   = 3'd1,
      STATE_EX   = 3'd2,
      STATE_MEM  = 3'd3,
      STATE_WB   = 3'd4,
      STATE_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE      = 6'h00;
   localparam logic [5:0] OP_J          = 6'h02;
   localparam logic [5:0] OP_JAL        = 6'h03;
   localparam logic [5:0] OP_BEQ        = 6'h04;
   localparam logic [5:0] OP_BNE        = 6'h05;
   localparam logic [5:0] OP_ALUI_FIRST = 6'h08;
   localparam logic [5:0] OP_ALUI_LAST  = 6'h0F;
   localparam logic [5:0] OP_LW         = 6'h23;
   localparam logic [5:0] OP_SW         = 6'h2B;
   localparam logic [5:0] OP_HALT       = 6'h3E;

   typedef enum logic [2:0] {
      CLS_BRANCH  = 3'd0,
      CLS_MEM     = 3'd1,
      CLS_WB      = 3'd2,
      CLS_HALT    = 3'd3,
      CLS_ILLEGAL = 3'd4
   } op_class_t;

   // Selects the path an instruction takes after EX.
   function automatic op_class_t op_class(input logic [5:0] op);
      op_class_t cls;
      cls = CLS_ILLEGAL;
      if (op == OP_HALT)
         cls = CLS_HALT;
      else if (op == OP_LW || op == OP_SW)
         cls = CLS_MEM;
      else if (op == OP_BEQ || op == OP_BNE || op == OP_J)
         cls = CLS_BRANCH;
      else if (op == OP_JAL || op == OP_RTYPE ||
               (op >= OP_ALUI_FIRST && op <= OP_ALUI_LAST))
         cls = CLS_WB;
      return cls;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_ctrl_perf_ctr.sv
// ============================================================================
// Module      : perf_ctr
// Description : Active-cycle and retired-instruction counters, both 32-bit
//               and wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_ctr
   import mcycle_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  state_t      state,
   input  logic        run,
   input  logic        pc_we,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;
   logic        w_active;

   // An idle fetch (run low) and a parked core do not count as active.
   assign w_active = (state != STATE_HALT) && ((state != STATE_IF) || run);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if (w_active)
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (pc_we)
            r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;

endmodule

`default_nettype wire

// File: rtl/mcycle_ctrl.sv
// ============================================================================
// Module      : mcycle_ctrl
// Description : Multicycle IF/ID/EX/MEM/WB sequencer with memory handshakes,
//               PC/RF write strobes and sticky illegal-opcode halt.
//               Define PERF_CNT_EN to build the cycle/instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_ctrl
   import mcycle_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [5:0]  opcode,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic [2:0]  state,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   state_t    r_state;
   state_t    w_state_nxt;
   logic      r_illegal;
   logic      w_illegal_set;
   op_class_t w_cls;

   assign w_cls = op_class(opcode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= STATE_IF;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_illegal_set)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_illegal_set = 1'b0;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      pc_we         = 1'b0;
      rf_we         = 1'b0;
      halted        = 1'b0;
      case (r_state)
         STATE_IF: begin
            imem_req = run;
            if (run && imem_ready)
               w_state_nxt = STATE_ID;
         end
         STATE_ID: begin
            w_state_nxt = STATE_EX;
         end
         STATE_EX: begin
            case (w_cls)
               CLS_HALT:   w_state_nxt = STATE_HALT;
               CLS_MEM:    w_state_nxt = STATE_MEM;
               CLS_WB:     w_state_nxt = STATE_WB;
               CLS_BRANCH: begin
                  pc_we       = 1'b1;
                  w_state_nxt = STATE_IF;
               end
               default: begin
                  w_state_nxt   = STATE_HALT;
                  w_illegal_set = 1'b1;
               end
            endcase
         end
         STATE_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_SW);
            // Stores retire here; loads still need a writeback cycle.
            if (dmem_ready) begin
               if (opcode == OP_SW) begin
                  pc_we       = 1'b1;
                  w_state_nxt = STATE_IF;
               end else begin
                  w_state_nxt = STATE_WB;
               end
            end
         end
         STATE_WB: begin
            rf_we       = 1'b1;
            pc_we       = 1'b1;
            w_state_nxt = STATE_IF;
         end
         STATE_HALT: begin
            halted = 1'b1;
         end
         default: begin
            w_state_nxt   = STATE_HALT;
            w_illegal_set = 1'b1;
         end
      endcase
   end

   assign state   = r_state;
   assign illegal = r_illegal;

`ifdef PERF_CNT_EN
   perf_ctr u_perf_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (r_state),
      .run       (run),
      .pc_we     (pc_we),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================================
// Module      : tb_mcycle_ctrl
// Description : Self-checking bench for mcycle_ctrl: latency table, directed
//               corner sequences and randomized instruction traces.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcycle_ctrl;
   import mcycle_ctrl_pkg::*;

`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic [5:0]  opcode = '0;
   logic [2:0]  state;
   logic        imem_req, dmem_req, dmem_we, pc_we, rf_we, halted, illegal;
   logic [31:0] cycle_cnt, instr_cnt;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] m_cyc = '0;
   logic [31:0] m_ins = '0;
   logic        m_ill = 1'b0;

   mcycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .pc_we(pc_we), .rf_we(rf_we), .halted(halted), .illegal(illegal),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic ireq, dreq, dwe, pcwe, rfwe, hlt, ill;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      int         lat;
      logic       rf, we, hlt, ill;
   } vec_t;

   function automatic obs_t observe();
      return '{state, imem_req, dmem_req, dmem_we, pc_we, rf_we, halted, illegal};
   endfunction

   function automatic obs_t mk(input logic [2:0] st, input logic ireq, dreq,
                               dwe, pcwe, rfwe, hlt);
      return '{st, ireq, dreq, dwe, pcwe, rfwe, hlt, m_ill};
   endfunction

   // 0 branch/jump, 1 load/store, 2 writeback ALU/JAL, 3 halt, 4 undefined
   function automatic int kind(input logic [5:0] op);
      if (op == OP_HALT) return 3;
      if (op == OP_LW || op == OP_SW) return 1;
      if (op inside {OP_BEQ, OP_BNE, OP_J}) return 0;
      if (op inside {OP_RTYPE, OP_JAL, [6'h08:6'h0F]}) return 2;
      return 4;
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // One clock of stimulus, checked against the expected outputs and counters.
   task automatic step(input logic r, ir, dr, input logic [5:0] op,
                       input obs_t e, input string nm);
      @(negedge clk);
      run = r; imem_ready = ir; dmem_ready = dr; opcode = op;
      #1;
      check({nm, " outputs"}, 64'(observe()), 64'(e));
      check({nm, " cycle_cnt"}, 64'(cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
      check({nm, " instr_cnt"}, 64'(instr_cnt), PERF ? 64'(m_ins) : 64'd0);
      if (e.st != STATE_HALT && (e.st != STATE_IF || r)) m_cyc = m_cyc + 32'd1;
      if (e.pcwe) m_ins = m_ins + 32'd1;
   endtask

   // Expected per-cycle trace of one instruction, built from its class.
   task automatic run_instr(input logic [5:0] op, input int nidle, nifw, nmemw);
      int  k;
      logic sw;
      k  = kind(op);
      sw = (op == OP_SW);
      for (int i = 0; i < nidle; i++)
         step(1'b0, rb(), rb(), 6'($urandom), mk(STATE_IF, 0, 0, 0, 0, 0, 0), "if_idle");
      for (int i = 0; i < nifw; i++)
         step(1'b1, 1'b0, rb(), 6'($urandom), mk(STATE_IF, 1, 0, 0, 0, 0, 0), "if_wait");
      step(1'b1, 1'b1, rb(), 6'($urandom), mk(STATE_IF, 1, 0, 0, 0, 0, 0), "if_fetch");
      step(rb(), rb(), rb(), 6'($urandom), mk(STATE_ID, 0, 0, 0, 0, 0, 0), "id");
      step(rb(), rb(), rb(), op, mk(STATE_EX, 0, 0, 0, k == 0, 0, 0), "ex");
      if (k == 1) begin
         for (int i = 0; i < nmemw; i++)
            step(rb(), rb(), 1'b0, op, mk(STATE_MEM, 0, 1, sw, 0, 0, 0), "mem_wait");
         step(rb(), rb(), 1'b1, op, mk(STATE_MEM, 0, 1, sw, sw, 0, 0), "mem_done");
      end
      if (k == 2 || (k == 1 && !sw))
         step(rb(), rb(), rb(), op, mk(STATE_WB, 0, 0, 0, 1, 1, 0), "wb");
      if (k >= 3) begin
         m_ill = (k == 4);
         for (int i = 0; i < 3; i++)
            step(rb(), rb(), rb(), 6'($urandom), mk(STATE_HALT, 0, 0, 0, 0, 0, 1), "halt");
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; run = 1'b1;
      m_cyc = '0; m_ins = '0; m_ill = 1'b0;
      #1;
      check("reset outputs run=1", 64'(observe()), 64'(mk(STATE_IF, 1, 0, 0, 0, 0, 0)));
      check("reset counters", {cycle_cnt, instr_cnt}, 64'd0);
      run = 1'b0;
      #1;
      check("reset outputs run=0", 64'(observe()), 64'(mk(STATE_IF, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t        tbl[13];
      logic [5:0]  seq[4];
      logic [5:0]  ops[16];
      logic [31:0] pcmask, rfmask, exp_pc, exp_rf;
      logic [5:0]  op;
      int          cnt, k;
      logic        rf, we, done;

      tbl = '{'{OP_RTYPE, 4, 1, 0, 0, 0}, '{6'h08, 4, 1, 0, 0, 0}, '{6'h0F, 4, 1, 0, 0, 0},
              '{OP_JAL, 4, 1, 0, 0, 0},   '{OP_LW, 5, 1, 0, 0, 0},  '{OP_SW, 4, 0, 1, 0, 0},
              '{OP_BEQ, 3, 0, 0, 0, 0},   '{OP_BNE, 3, 0, 0, 0, 0}, '{OP_J, 3, 0, 0, 0, 0},
              '{OP_HALT, 4, 0, 0, 1, 0},  '{6'h3F, 4, 0, 0, 1, 1},  '{6'h07, 4, 0, 0, 1, 1},
              '{6'h10, 4, 0, 0, 1, 1}};
      seq = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ};
      ops = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, 6'h08, 6'h09, 6'h0A,
              6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, OP_LW, OP_SW, OP_LW};

      do_reset();

      // Zero-wait latency table: cycles from IF entry to pc_we (or halted).
      for (int v = 0; v < 13; v++) begin
         cnt = 0; rf = 0; we = 0; done = 0;
         while (!done && cnt < 20) begin
            @(negedge clk);
            run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = tbl[v].op;
            #1;
            cnt++;
            rf = rf | rf_we;
            we = we | dmem_we;
            if (pc_we || halted) done = 1;
         end
         check($sformatf("latency op=%0h", tbl[v].op), 64'(cnt), 64'(tbl[v].lat));
         check($sformatf("rf/we op=%0h", tbl[v].op), {62'd0, rf, we}, {62'd0, tbl[v].rf, tbl[v].we});
         if (tbl[v].hlt) begin
            check($sformatf("halt op=%0h", tbl[v].op), {62'd0, halted, illegal},
                  {62'd0, 1'b1, tbl[v].ill});
            do_reset();
         end
      end

      // Back-to-back R-type, LW, SW, BEQ with ready held high.
      do_reset();
      pcmask = '0; rfmask = '0; k = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = seq[k];
         #1;
         if (rf_we) rfmask[c] = 1'b1;
         if (pc_we) begin
            pcmask[c] = 1'b1;
            if (k < 3) k++;
         end
      end
      exp_pc = (32'd1 << 4) | (32'd1 << 9) | (32'd1 << 13) | (32'd1 << 16);
      exp_rf = (32'd1 << 4) | (32'd1 << 9);
      check("b2b pc_we cycles", 64'(pcmask), 64'(exp_pc));
      check("b2b rf_we cycles", 64'(rfmask), 64'(exp_rf));

      // Directed multi-cycle corners through the trace model.
      do_reset();
      run_instr(OP_LW, 0, 0, 3);
      run_instr(OP_RTYPE, 5, 0, 0);
      run_instr(OP_SW, 2, 2, 2);
      run_instr(6'h3F, 0, 0, 0);
      do_reset();

      // Asynchronous reset while a data access is pending.
      step(1'b1, 1'b1, 1'b0, OP_LW, mk(STATE_IF, 1, 0, 0, 0, 0, 0), "ar_if");
      step(1'b1, 1'b0, 1'b0, OP_LW, mk(STATE_ID, 0, 0, 0, 0, 0, 0), "ar_id");
      step(1'b1, 1'b0, 1'b0, OP_LW, mk(STATE_EX, 0, 0, 0, 0, 0, 0), "ar_ex");
      step(1'b1, 1'b0, 1'b0, OP_LW, mk(STATE_MEM, 0, 1, 0, 0, 0, 0), "ar_mem");
      #1 rst_n = 1'b0;
      #1;
      check("async reset state/dmem_req", {61'd0, state, dmem_req}, {61'd0, STATE_IF, 1'b0});
      do_reset();

      // Ten zero-wait R-type instructions.
      for (int i = 0; i < 10; i++) run_instr(OP_RTYPE, 0, 0, 0);
      @(negedge clk);
      run = 1'b0;
      #1;
      check("ten rtype cycle_cnt", 64'(cycle_cnt), PERF ? 64'd40 : 64'd0);
      check("ten rtype instr_cnt", 64'(instr_cnt), PERF ? 64'd10 : 64'd0);

      // Randomized traces.
      do_reset();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 14) == 0) begin
            if ($urandom_range(0, 1) == 1) op = OP_HALT;
            else begin
               op = 6'($urandom);
               while (kind(op) != 4) op = 6'($urandom);
            end
            run_instr(op, 0, 0, 0);
            do_reset();
         end else begin
            run_instr(ops[$urandom_range(0, 15)], $urandom_range(0, 2),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
